// File: rtl/serial_tx_pkg.sv
// Shared types and helpers for the serial transmit engine.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } tx_state_t;

    function automatic int unsigned calc_beats(input int unsigned data_w,
                                               input int unsigned lanes);
        return data_w / lanes;
    endfunction

endpackage

// File: rtl/tx_baud_gen.sv
// Beat-enable divider: counts 0..CLK_DIV-1 while running, ticks on the wrap.
module tx_baud_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_run,
    output logic o_tick
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == LAST);
    assign o_tick = i_run && w_wrap;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_tx_engine.sv
// Double-buffered serial transmitter: holding register feeds a shift register
// that emits LANES bits per beat at a CLK_DIV-divided rate.
module serial_tx_engine
    import serial_tx_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned LANES     = 1,
    parameter int unsigned CLK_DIV   = 4,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              SampleData,
    input  logic              StartTx,
    input  logic              Abort,
    output logic              HoldFull,
    output logic              Overrun,
    output logic [LANES-1:0]  DataOut,
    output logic              BeatValid,
    output logic              TxBusy,
    output logic              TxDone
);

    localparam int unsigned BEATS = calc_beats(DATA_W, LANES);
    localparam int unsigned BW    = $clog2(BEATS + 1);

    tx_state_t         r_state, w_state_nxt;
    logic [DATA_W-1:0] r_hold, w_hold_nxt;
    logic              r_hold_full, w_hold_full_nxt;
    logic [DATA_W-1:0] r_shift, w_shift_nxt;
    logic [BW-1:0]     r_beat, w_beat_nxt;
    logic [LANES-1:0]  r_data_out, w_data_nxt;
    logic              r_beat_valid, w_valid_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              r_overrun, w_overrun_nxt;
    logic              w_launch, w_abort, w_tick;

    function automatic logic [LANES-1:0] head(input logic [DATA_W-1:0] w);
        if (MSB_FIRST) return w[DATA_W-1 -: LANES];
        else           return w[LANES-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
        if (MSB_FIRST) return w << LANES;
        else           return w >> LANES;
    endfunction

    tx_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
        .i_clk   (Clk),
        .i_rst_n (Reset),
        .i_clear (w_launch || w_abort),
        .i_run   (r_state == SHIFT),
        .o_tick  (w_tick)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_beat_nxt      = r_beat;
        w_data_nxt      = r_data_out;
        w_valid_nxt     = 1'b0;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_launch        = 1'b0;
        w_abort         = 1'b0;
        w_hold_nxt      = r_hold;
        w_hold_full_nxt = r_hold_full;
        w_overrun_nxt   = 1'b0;

        case (r_state)
            IDLE, DONE: begin
                if (r_hold_full && StartTx) begin
                    w_launch    = 1'b1;
                    w_state_nxt = SHIFT;
                    w_shift_nxt = advance(r_hold);
                    w_data_nxt  = head(r_hold);
                    w_beat_nxt  = BW'(1);
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SHIFT: begin
                if (Abort) begin
                    w_abort     = 1'b1;
                    w_state_nxt = IDLE;
                    w_data_nxt  = '0;
                    w_busy_nxt  = 1'b0;
                    w_beat_nxt  = '0;
                end else if (w_tick) begin
                    // r_beat counts slices already presented; the final tick only closes the word
                    if (r_beat < BW'(BEATS)) begin
                        w_data_nxt  = head(r_shift);
                        w_shift_nxt = advance(r_shift);
                        w_beat_nxt  = r_beat + BW'(1);
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_state_nxt = DONE;
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_data_nxt  = '0;
                        w_beat_nxt  = '0;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // A write into a full holding register is only legal when that word leaves this cycle
        if (SampleData) begin
            if (!r_hold_full || w_launch) begin
                w_hold_nxt      = DataIn;
                w_hold_full_nxt = 1'b1;
            end else begin
                w_overrun_nxt   = 1'b1;
            end
        end else if (w_launch) begin
            w_hold_full_nxt = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state      <= IDLE;
            r_hold       <= '0;
            r_hold_full  <= 1'b0;
            r_shift      <= '0;
            r_beat       <= '0;
            r_data_out   <= '0;
            r_beat_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_hold       <= w_hold_nxt;
            r_hold_full  <= w_hold_full_nxt;
            r_shift      <= w_shift_nxt;
            r_beat       <= w_beat_nxt;
            r_data_out   <= w_data_nxt;
            r_beat_valid <= w_valid_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_overrun    <= w_overrun_nxt;
        end
    end

    assign HoldFull  = r_hold_full;
    assign Overrun   = r_overrun;
    assign DataOut   = r_data_out;
    assign BeatValid = r_beat_valid;
    assign TxBusy    = r_busy;
    assign TxDone    = r_done;

endmodule

// File: tb/tb_serial_tx_engine.sv
// Two engine configurations driven with shared stimulus, each checked every
// cycle against a timeline model built from launch times and slice arithmetic.
module tb_serial_tx_engine;

    localparam int unsigned LN [2] = '{1, 4};
    localparam int unsigned DV [2] = '{4, 1};
    localparam int unsigned MS [2] = '{0, 1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] din = '0;
    logic        sample = 1'b0, start = 1'b0, abort = 1'b0;

    logic       d0_hf, d0_ovr, d0_valid, d0_busy, d0_done;
    logic [0:0] d0_data;
    logic       d1_hf, d1_ovr, d1_valid, d1_busy, d1_done;
    logic [3:0] d1_data;

    int n_cmp = 0;
    int n_err = 0;
    int n = 0;

    bit          m_active [2];
    int          m_e0     [2];
    bit          m_hf     [2];
    logic [31:0] m_hold   [2];
    logic [31:0] m_word   [2];
    logic [31:0] e_data   [2];
    bit          e_valid  [2], e_busy [2], e_done [2], e_hf [2], e_ovr [2];
    int          obs_launch [2];
    bit          prev_busy  [2];

    always #5 clk = ~clk;

    serial_tx_engine u_dut0 (
        .Clk(clk), .Reset(rst_n), .DataIn(din), .SampleData(sample),
        .StartTx(start), .Abort(abort), .HoldFull(d0_hf), .Overrun(d0_ovr),
        .DataOut(d0_data), .BeatValid(d0_valid), .TxBusy(d0_busy), .TxDone(d0_done)
    );

    serial_tx_engine #(.DATA_W(32), .LANES(4), .CLK_DIV(1), .MSB_FIRST(1'b1)) u_dut1 (
        .Clk(clk), .Reset(rst_n), .DataIn(din), .SampleData(sample),
        .StartTx(start), .Abort(abort), .HoldFull(d1_hf), .Overrun(d1_ovr),
        .DataOut(d1_data), .BeatValid(d1_valid), .TxBusy(d1_busy), .TxDone(d1_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] slice(input int i, input logic [31:0] w, input int j);
        logic [31:0] mask;
        mask = (32'h1 << LN[i]) - 32'h1;
        if (MS[i] != 0) return (w >> (32 - LN[i] * (j + 1))) & mask;
        else            return (w >> (LN[i] * j)) & mask;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0; m_e0[i] = 0; m_hf[i] = 1'b0;
            m_hold[i] = '0; m_word[i] = '0;
            obs_launch[i] = -100000; prev_busy[i] = 1'b0;
        end
    endtask

    // A word launched at edge E0 shows slice k at E0+k*DIV and completes at E0+BEATS*DIV.
    task automatic model_edge(input int i, input bit s, input bit st, input bit ab,
                              input logic [31:0] d);
        int  total, k;
        bit  in_shift, launch;
        total    = (32 / LN[i]) * DV[i];
        in_shift = m_active[i] && (n > m_e0[i]) && (n <= m_e0[i] + total);
        launch   = m_hf[i] && st && !in_shift;
        if (ab && in_shift) m_active[i] = 1'b0;
        if (launch) begin
            m_active[i] = 1'b1; m_e0[i] = n; m_word[i] = m_hold[i];
        end
        e_ovr[i] = 1'b0;
        if (s) begin
            if (!m_hf[i] || launch) begin m_hold[i] = d; m_hf[i] = 1'b1; end
            else e_ovr[i] = 1'b1;
        end else if (launch) begin
            m_hf[i] = 1'b0;
        end
        e_data[i] = '0; e_valid[i] = 1'b0; e_busy[i] = 1'b0; e_done[i] = 1'b0;
        if (m_active[i]) begin
            k = n - m_e0[i];
            if (k < total) begin
                e_data[i]  = slice(i, m_word[i], k / DV[i]);
                e_valid[i] = (k % DV[i]) == 0;
                e_busy[i]  = 1'b1;
            end else if (k == total) begin
                e_done[i] = 1'b1;
            end
        end
        e_hf[i] = m_hf[i];
    endtask

    task automatic compare_outputs();
        logic [31:0] o_data [2];
        bit o_valid [2], o_busy [2], o_done [2], o_hf [2], o_ovr [2];
        o_data[0] = 32'(d0_data); o_valid[0] = d0_valid; o_busy[0] = d0_busy;
        o_done[0] = d0_done; o_hf[0] = d0_hf; o_ovr[0] = d0_ovr;
        o_data[1] = 32'(d1_data); o_valid[1] = d1_valid; o_busy[1] = d1_busy;
        o_done[1] = d1_done; o_hf[1] = d1_hf; o_ovr[1] = d1_ovr;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("d%0d.DataOut@%0d", i, n), o_data[i], e_data[i]);
            check($sformatf("d%0d.BeatValid@%0d", i, n), 32'(o_valid[i]), 32'(e_valid[i]));
            check($sformatf("d%0d.TxBusy@%0d", i, n), 32'(o_busy[i]), 32'(e_busy[i]));
            check($sformatf("d%0d.TxDone@%0d", i, n), 32'(o_done[i]), 32'(e_done[i]));
            check($sformatf("d%0d.HoldFull@%0d", i, n), 32'(o_hf[i]), 32'(e_hf[i]));
            check($sformatf("d%0d.Overrun@%0d", i, n), 32'(o_ovr[i]), 32'(e_ovr[i]));
            if (o_valid[i] && !prev_busy[i]) obs_launch[i] = n;
            if (o_done[i])
                check($sformatf("d%0d.latency@%0d", i, n), 32'(n - obs_launch[i]),
                      32'((32 / LN[i]) * DV[i]));
            prev_busy[i] = o_busy[i];
        end
    endtask

    task automatic cycle(input bit s, input bit st, input bit ab, input logic [31:0] d);
        @(negedge clk);
        sample = s; start = st; abort = ab; din = d;
        for (int i = 0; i < 2; i++) model_edge(i, s, st, ab, d);
        @(posedge clk);
        #1;
        compare_outputs();
        n++;
    endtask

    task automatic async_reset();
        @(negedge clk);
        sample = 1'b0; start = 1'b0; abort = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst.d0.DataOut", 32'(d0_data), 32'h0);
        check("rst.d0.TxBusy", 32'(d0_busy), 32'h0);
        check("rst.d0.HoldFull", 32'(d0_hf), 32'h0);
        check("rst.d0.BeatValid", 32'(d0_valid), 32'h0);
        check("rst.d1.DataOut", 32'(d1_data), 32'h0);
        check("rst.d1.TxBusy", 32'(d1_busy), 32'h0);
        check("rst.d1.HoldFull", 32'(d1_hf), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit          s, st, ab;
        logic [31:0] d;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("por.d0.TxBusy", 32'(d0_busy), 32'h0);
        check("por.d0.HoldFull", 32'(d0_hf), 32'h0);
        check("por.d1.DataOut", 32'(d1_data), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed walk: first word, back-to-back second word, overrun, abort, reset mid-word.
        for (int t = 0; t < 328; t++) begin
            s = 1'b0; st = 1'b1; ab = 1'b0; d = $urandom;
            case (t)
                0:   begin st = 1'b0; s = 1'b1; d = 32'hA5A5_0F0F; end
                20:  begin s = 1'b1; d = 32'hDEAD_BEEF; end
                160: begin s = 1'b1; d = 32'hC0DE_CAFE; end
                170: begin s = 1'b1; d = 32'h1111_2222; end
                280: begin s = 1'b1; d = 32'h3333_4444; end
                300: ab = 1'b1;
                default: ;
            endcase
            if (t > 300 && t <= 305) st = 1'b0;
            cycle(s, st, ab, d);
        end
        async_reset();
        repeat (10) cycle(1'b0, 1'b1, 1'b0, $urandom);

        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 1499) == 0) async_reset();
            cycle(($urandom % 8) == 0, ($urandom % 4) != 0, ($urandom % 50) == 0, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_tx_engine.md
# serial_tx_engine

Parametrised single-clock serial transmitter for the binary calculator datapath: it accepts result words into a holding register, then shifts each word out LANES bits per beat at a programmable rate. A built-in clock-enable divider replaces the separate transmit clock. Double buffering supports back-to-back words; the block adds abort, selectable bit order and overrun reporting. It sits between the calculator result register and the serial link/display driver.

## Interface
- DATA_W, 32, word width; must be a multiple of LANES
- LANES, 1, bits presented per beat (1, 2, 4, 8)
- CLK_DIV, 4, Clk cycles per beat (>=1)
- MSB_FIRST, 0, 0 = LSB slice first, 1 = MSB slice first
- Clk  in  1  single clock, all logic on rising edge
- Reset  in  1  asynchronous, active-low; all state cleared while low
- DataIn  in  DATA_W  word to transmit
- SampleData  in  1  write strobe into holding register
- StartTx  in  1  level enable; a word is launched only while high
- Abort  in  1  cancel current word
- HoldFull  out  1  holding register occupied
- Overrun  out  1  one-cycle pulse: SampleData dropped
- DataOut  out  LANES  current slice
- BeatValid  out  1  one-cycle pulse with each new DataOut slice
- TxBusy  out  1  word in flight
- TxDone  out  1  one-cycle pulse: word completed

## Operation
- Reset values: HoldFull=0, Overrun=0, DataOut=0, BeatValid=0, TxBusy=0, TxDone=0, state IDLE, counters 0.
- BEATS = DATA_W/LANES.
- Holding register:
  - SampleData while HoldFull=0 captures DataIn and sets HoldFull.
  - SampleData while HoldFull=1 is accepted only if the holding register is being launched in the same cycle. HoldFull then stays 1.
  - Otherwise the write is dropped: Overrun pulses and the old word is kept.
- States: IDLE, SHIFT, DONE.
- IDLE: if HoldFull and StartTx, launch the word.
  - Shift register takes the holding word; HoldFull clears, unless a same-cycle SampleData applies.
  - DataOut gets slice 0; BeatValid and TxBusy are set; state becomes SHIFT.
- SHIFT:
  - Divider counts 0..CLK_DIV-1.
  - On wrap with beats remaining, present the next slice and pulse BeatValid.
  - After the last slice has been held CLK_DIV cycles, go to DONE: TxDone=1, TxBusy=0, DataOut=0.
  - StartTx is ignored mid-word.
- DONE (1 cycle): if HoldFull and StartTx, launch as from IDLE (back-to-back); else go to IDLE.
- Abort in SHIFT: next state IDLE; DataOut=0, TxBusy=0, no TxDone; holding register untouched. Abort in IDLE/DONE has no effect and does not suppress a launch.
- Slice order: MSB_FIRST=0 sends DataIn[LANES-1:0] first; MSB_FIRST=1 sends DataIn[DATA_W-1:DATA_W-LANES] first.
- Reset low mid-word: immediate return to reset values; the in-flight and held words are lost.

## Timing
- Launch edge E0: first slice and BeatValid at E0 (registered, zero extra latency after the IDLE decision).
- Slice k appears at E0 + k*CLK_DIV, for k = 0..BEATS-1.
- TxDone at E0 + BEATS*CLK_DIV.
- Back-to-back next E0 = previous E0 + BEATS*CLK_DIV + 1.
- CLK_DIV=1: BeatValid is high every SHIFT cycle.
- Beat counter width is $clog2(BEATS+1); divider width is $clog2(CLK_DIV), minimum 1.

## Structure
- Package serial_tx_pkg: state enum typedef (IDLE, SHIFT, DONE) and a helper function computing BEATS.
- Sub-module tx_baud_gen: divider that produces a beat-enable. It is cleared on launch and abort.
- Top module holds the holding register, shift register, FSM and output registers.

## Test plan
- Defaults, DataIn=32'hA5A5_0F0F, SampleData pulse, then StartTx=1 -> DataOut serial LSB-first 1,1,1,1,0,0,0,0,…; BeatValid every 4 cycles; TxDone exactly 128 cycles after launch; TxBusy low with TxDone.
- LANES=4, MSB_FIRST=1, CLK_DIV=1, word 32'h1234_5678 -> DataOut 1,2,3,4,5,6,7,8 on consecutive cycles; TxDone on the 9th cycle.
- Second word 32'hDEAD_BEEF loaded during the first word, StartTx held -> second launch exactly 1 cycle after TxDone; HoldFull drops at that launch.
- Third SampleData while HoldFull=1 and shifting -> Overrun pulse for one cycle; the held word is transmitted unchanged.
- Abort at beat 10 -> DataOut=0 and TxBusy=0 next cycle; no TxDone; a subsequent StartTx sends the held word from slice 0.
- Reset driven low at beat 5 -> all outputs reset asynchronously; after release, no TxDone and HoldFull=0.
